// File: rtl/iob_pcie_rx_chnl_ctrl.sv
// iob_pcie_rx_chnl_ctrl
// RX channel transaction controller. A hardware FSM does the CHNL_RX / ACK
// handshake, takes beats until RX_LEN words have been received, and buffers
// them in a synchronous FIFO. The FIFO head is width-converted from PCI_W-bit
// beats into 32-bit words on a valid/ready stream.
//
// Parameters: PCI_W (64 or 128), LEN_W (length counter width),
//             FIFO_ADDR_W (FIFO depth = 2**FIFO_ADDR_W beats)
// Ports:
//   clk, rst (async, active-low)
//   chnl_rx_i / chnl_rx_last_i / chnl_rx_len_i / chnl_rx_off_i : transaction request
//   chnl_rx_data_i / chnl_rx_data_valid_i / chnl_rx_data_ren_o  : beat stream
//   chnl_rx_ack_o                                               : 1-cycle acknowledge
//   out_data_o / out_valid_o / out_ready_i                      : 32-bit word stream
//   busy_o, done_o, last_o, off_o, level_o                      : status
// Optional build macro IOB_PCIE_RX_STATUS_EN adds:
//   err_o   : sticky early-termination flag, cleared at ACK
//   words_o : words accepted in the current/last transaction, cleared at ACK
module iob_pcie_rx_chnl_ctrl #(
    parameter int PCI_W       = 64,
    parameter int LEN_W       = 32,
    parameter int FIFO_ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   chnl_rx_i,
    input  logic                   chnl_rx_last_i,
    input  logic [LEN_W-1:0]       chnl_rx_len_i,
    input  logic [30:0]            chnl_rx_off_i,
    input  logic [PCI_W-1:0]       chnl_rx_data_i,
    input  logic                   chnl_rx_data_valid_i,
    output logic                   chnl_rx_data_ren_o,
    output logic                   chnl_rx_ack_o,
    output logic [31:0]            out_data_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   last_o,
    output logic [30:0]            off_o,
    output logic [FIFO_ADDR_W:0]   level_o
`ifdef IOB_PCIE_RX_STATUS_EN
    ,
    output logic                   err_o,
    output logic [LEN_W-1:0]       words_o
`endif
);

    localparam int R     = PCI_W / 32;
    localparam int CNT_W = $clog2(R) + 1;
    localparam int ENT_W = PCI_W + CNT_W;
    localparam int DEPTH = 1 << FIFO_ADDR_W;

    localparam logic [LEN_W-1:0]     R_LEN      = LEN_W'(R);
    localparam logic [FIFO_ADDR_W:0] LEVEL_FULL = {1'b1, {FIFO_ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_DATA,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [LEN_W-1:0]       remaining_q;
    logic                   last_q;
    logic [30:0]            off_q;

    logic [ENT_W-1:0]       mem [DEPTH];
    logic [FIFO_ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_ADDR_W:0]   level_q;
    logic [CNT_W-1:0]       lane_q;

    logic                   full, empty, ren, accept, push, pop, out_fire, lane_last;
    logic                   ack, done, early_term;
    logic [LEN_W-1:0]       beat_cnt_w, remaining_after;
    logic [CNT_W-1:0]       beat_cnt;
    logic [ENT_W-1:0]       head;
    logic [PCI_W-1:0]       head_data;
    logic [CNT_W-1:0]       head_cnt;

    assign full  = (level_q == LEVEL_FULL);
    assign empty = (level_q == '0);

    // Enable is based only on the registered level: a pop in the same cycle
    // does not free a slot for the beat being offered now.
    assign ren    = (state_q == S_DATA) && !full;
    assign accept = ren && chnl_rx_data_valid_i;

    assign beat_cnt_w      = (remaining_q < R_LEN) ? remaining_q : R_LEN;
    assign beat_cnt        = CNT_W'(beat_cnt_w);
    assign remaining_after = remaining_q - beat_cnt_w;

    always_comb begin
        state_d    = state_q;
        ack        = 1'b0;
        done       = 1'b0;
        early_term = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (chnl_rx_i) state_d = S_ACK;
            end
            S_ACK: begin
                ack     = 1'b1;
                state_d = (remaining_q == '0) ? S_DONE : S_DATA;
            end
            S_DATA: begin
                if (accept && remaining_after == '0) begin
                    state_d = S_DONE;
                end else if (!chnl_rx_i && !accept) begin
                    state_d    = S_DONE;
                    early_term = 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            last_q      <= 1'b0;
            off_q       <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && chnl_rx_i) begin
                remaining_q <= chnl_rx_len_i;
                last_q      <= chnl_rx_last_i;
                off_q       <= chnl_rx_off_i;
            end else if (accept) begin
                remaining_q <= remaining_after;
            end
        end
    end

    // Each FIFO entry carries its valid word count so a partial last beat
    // pops after its final valid word.
    assign push      = accept;
    assign head      = mem[rd_ptr_q];
    assign head_data = head[PCI_W-1:0];
    assign head_cnt  = head[ENT_W-1:PCI_W];
    assign out_fire  = !empty && out_ready_i;
    assign lane_last = (lane_q == head_cnt - CNT_W'(1));
    assign pop       = out_fire && lane_last;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {beat_cnt, chnl_rx_data_i};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            lane_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + FIFO_ADDR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_ADDR_W'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + (FIFO_ADDR_W+1)'(1);
                2'b01:   level_q <= level_q - (FIFO_ADDR_W+1)'(1);
                default: level_q <= level_q;
            endcase
            if (out_fire) lane_q <= lane_last ? '0 : lane_q + CNT_W'(1);
        end
    end

`ifdef IOB_PCIE_RX_STATUS_EN
    logic             err_q;
    logic [LEN_W-1:0] words_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q   <= 1'b0;
            words_q <= '0;
        end else if (state_q == S_ACK) begin
            err_q   <= 1'b0;
            words_q <= '0;
        end else begin
            if (early_term && remaining_q != '0) err_q <= 1'b1;
            if (accept) words_q <= words_q + beat_cnt_w;
        end
    end

    assign err_o   = err_q;
    assign words_o = words_q;
`else
    // Status counters are not built; early_term only steers the FSM.
`endif

    assign chnl_rx_data_ren_o = ren;
    assign chnl_rx_ack_o      = ack;
    assign done_o             = done;
    assign busy_o             = (state_q != S_IDLE);
    assign last_o             = last_q;
    assign off_o              = off_q;
    assign level_o            = level_q;
    assign out_valid_o        = !empty;
    assign out_data_o         = empty ? '0 : head_data[32*lane_q +: 32];

endmodule
